// File: rtl/wb_ram_burst.sv
// Single-port Wishbone B3 slave RAM with registered-feedback incrementing/wrapping bursts.
// Optional out-of-range error response is enabled by defining WB_RAM_ERR_EN.
module wb_ram_burst #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
`ifdef WB_RAM_ERR_EN
  ,
  parameter int unsigned DEPTH        = 2 ** ADDR_WIDTH
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [SELECT_WIDTH-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic                    ack_o
`ifdef WB_RAM_ERR_EN
  ,
  output logic                    err_o
`endif
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [DATA_WIDTH-1:0] mem [2 ** ADDR_WIDTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_adr_q, cur_adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  mem_we;
  logic                  beat;
  logic [ADDR_WIDTH-1:0] wrap_mask, inc_adr, nxt_adr;
  logic                  start_ok, nxt_ok;

  assign beat    = cyc_i & stb_i;
  assign inc_adr = cur_adr_q + 1'b1;

  // Linear uses an all-ones mask, so the same merge yields a plain increment.
  always_comb begin
    wrap_mask = '1;
    case (bte_i)
      2'b01:   wrap_mask = ADDR_WIDTH'(3);
      2'b10:   wrap_mask = ADDR_WIDTH'(7);
      2'b11:   wrap_mask = ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    nxt_adr = (cur_adr_q & ~wrap_mask) | (inc_adr & wrap_mask);
  end

`ifdef WB_RAM_ERR_EN
  logic err_q, err_d;
  assign start_ok = 32'(adr_i) < DEPTH;
  assign nxt_ok   = 32'(nxt_adr) < DEPTH;
  assign err_o    = err_q;
`else
  assign start_ok = 1'b1;
  assign nxt_ok   = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cur_adr_d = cur_adr_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    mem_we    = 1'b0;
`ifdef WB_RAM_ERR_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          cur_adr_d = adr_i;
          state_d   = StActive;
          if (start_ok) begin
            ack_d = 1'b1;
            dat_d = mem[adr_i];
          end else begin
            dat_d = '0;
`ifdef WB_RAM_ERR_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      StActive: begin
        state_d = StIdle;
        // Only an acked beat may write; an err beat always ends the cycle.
        if (beat && ack_q) begin
          mem_we = we_i;
          if (cti_i == 3'b010) begin
            state_d   = StActive;
            cur_adr_d = nxt_adr;
            if (nxt_ok) begin
              ack_d = 1'b1;
              dat_d = mem[nxt_adr];
            end else begin
              dat_d = '0;
`ifdef WB_RAM_ERR_EN
              err_d = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_adr_q <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
`ifdef WB_RAM_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cur_adr_q <= cur_adr_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
`ifdef WB_RAM_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < SELECT_WIDTH; k++) begin
        if (sel_i[k]) mem[cur_adr_q][8*k +: 8] <= dat_i[8*k +: 8];
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;

endmodule

// File: tb/tb_wb_ram_burst.sv
// Self-checking bench for wb_ram_burst: directed scenarios plus random bursts
// checked against an array-based memory model with arithmetic burst addressing.
module tb_wb_ram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        cyc_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        ack_o;
`ifdef WB_RAM_ERR_EN
  logic        err_o;
`endif

  always #5 clk = ~clk;

  wb_ram_burst dut (
    .clk   (clk),
    .rst   (rst),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we_i),
    .sel_i (sel_i),
    .stb_i (stb_i),
    .cyc_i (cyc_i),
    .cti_i (cti_i),
    .bte_i (bte_i),
    .ack_o (ack_o)
`ifdef WB_RAM_ERR_EN
    ,
    .err_o (err_o)
`endif
  );

  logic [31:0] mem_m [512];
  logic [31:0] wbuf  [512];
  logic [3:0]  sbuf  [512];
  logic [2:0]  end_ctis [7];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Address of beat i of a burst starting at start, from the burst-type rules.
  function automatic logic [8:0] beat_adr(input logic [8:0] start, input logic [1:0] bte,
                                          input int i);
    int s, n;
    s = int'(start);
    if (bte == 2'b00) return 9'((s + i) % 512);
    n = 2 << bte;
    return 9'(s - (s % n) + ((s % n) + i) % n);
  endfunction

  // Runs an n-beat cycle; rst_at >= 0 pulses reset during that beat's ack cycle.
  task automatic burst(input logic [8:0] start, input logic [1:0] bte, input int n,
                       input logic we, input logic chk, input logic [2:0] end_cti,
                       input int rst_at);
    logic [8:0] a;
    a     = start;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    adr_i = start;
    bte_i = bte;
    we_i  = we;
    cti_i = (n > 1) ? 3'b010 : end_cti;
    dat_i = wbuf[0];
    sel_i = sbuf[0];
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      a = beat_adr(start, bte, i);
      check("ack_beat", 32'(ack_o), 32'd1);
      if (chk) check("dat_beat", dat_o, mem_m[a]);
      dat_i = wbuf[i];
      sel_i = sbuf[i];
      cti_i = (i < n - 1) ? 3'b010 : end_cti;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("ack_async_rst", 32'(ack_o), 32'd0);
        check("dat_async_rst", dat_o, 32'd0);
        @(posedge clk); #1;
        check("ack_in_rst", 32'(ack_o), 32'd0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (sbuf[i][k]) mem_m[a][8*k +: 8] = wbuf[i][8*k +: 8];
        end
      end
    end
    check("ack_end", 32'(ack_o), 32'd0);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    @(posedge clk); #1;
    check("ack_idle", 32'(ack_o), 32'd0);
    if (chk && !we) check("dat_hold", dat_o, mem_m[a]);
  endtask

  initial begin
    end_ctis = '{3'b000, 3'b111, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
    rst   = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    cti_i = '0;
    bte_i = '0;
    #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill every word so the model is fully defined.
    for (int i = 0; i < 512; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    burst(9'h000, 2'b00, 512, 1'b1, 1'b0, 3'b111, -1);

    // Classic write then read.
    wbuf[0] = 32'hA5A5_1234;
    sbuf[0] = 4'hF;
    burst(9'h010, 2'b00, 1, 1'b1, 1'b1, 3'b000, -1);
    burst(9'h010, 2'b00, 1, 1'b0, 1'b1, 3'b000, -1);
    check("t1_read", dat_o, 32'hA5A5_1234);

    // Single-lane write.
    wbuf[0] = 32'hFFFF_FFFF;
    sbuf[0] = 4'b0010;
    burst(9'h010, 2'b00, 1, 1'b1, 1'b1, 3'b000, -1);
    burst(9'h010, 2'b00, 1, 1'b0, 1'b1, 3'b000, -1);
    check("t2_read", dat_o, 32'hA5A5_FF34);

    // Linear read burst across the top of the address space.
    burst(9'h1FE, 2'b00, 4, 1'b0, 1'b1, 3'b111, -1);

    // Wrap8 write burst with beat index as data, then classic readback.
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'(i);
      sbuf[i] = 4'hF;
    end
    burst(9'h025, 2'b10, 8, 1'b1, 1'b1, 3'b111, -1);
    for (int a = 32'h20; a < 32'h28; a++) begin
      burst(9'(a), 2'b00, 1, 1'b0, 1'b1, 3'b000, -1);
      check("t4_wrap8", dat_o, (a >= 32'h25) ? 32'(a - 32'h25) : 32'(a - 32'h20 + 3));
    end

    // Reset during beat 2 of a write burst; beat 2 must not land.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    burst(9'h100, 2'b00, 4, 1'b1, 1'b1, 3'b111, 2);
    for (int i = 0; i < 3; i++) begin
      burst(9'(9'h100 + i), 2'b00, 1, 1'b0, 1'b1, 3'b000, -1);
    end

    // Random bursts, mixed types, lane masks and terminating cycle types.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = $urandom;
        sbuf[i] = 4'($urandom);
      end
      burst(9'($urandom), 2'($urandom), int'($urandom_range(1, 16)), 1'($urandom), 1'b1,
            end_ctis[$urandom_range(0, 6)], -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
